// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - field widths, command record and scheduler states
package pulse_sched_pkg;

  localparam int ENV_W   = 24;
  localparam int PHASE_W = 17;
  localparam int FREQ_W  = 9;
  localparam int AMP_W   = 16;
  localparam int CFG_W   = 4;

  localparam logic [1:0] TGT_QDRV = 2'd0;
  localparam logic [1:0] TGT_RDRV = 2'd1;
  localparam logic [1:0] TGT_RDLO = 2'd2;

  typedef struct packed {
    logic [ENV_W-1:0]   env;
    logic [PHASE_W-1:0] phase;
    logic [FREQ_W-1:0]  freq;
    logic [AMP_W-1:0]   amp;
    logic [CFG_W-1:0]   cfg;
  } pulse_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_TIME,
    S_WAIT_ELEM,
    S_ISSUE
  } sched_state_t;

endpackage

// File: rtl/pulse_cmd_fifo.sv
// rtl/pulse_cmd_fifo.sv - timed command FIFO; flush keeps a same-cycle push
module pulse_cmd_fifo
  import pulse_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int TIME_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [TIME_WIDTH-1:0]  push_time,
  input  pulse_cmd_t             push_cmd,
  output logic [TIME_WIDTH-1:0]  head_time,
  output pulse_cmd_t             head_cmd,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pulse_cmd_t            cmd_mem  [DEPTH];
  logic [TIME_WIDTH-1:0] time_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;

  assign head_time = time_mem[rd_ptr];
  assign head_cmd  = cmd_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr]  <= push_cmd;
      time_mem[wr_ptr] <= push_time;
    end
  end

  // Flush discards everything behind wr_ptr, so a push landing this cycle becomes the head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + AW'(push);
      count  <= CW'(push);
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pulse_sched.sv
// rtl/pulse_sched.sv - timed pulse command scheduler feeding qdrv/rdrv/rdlo elements
// Optional saturating late_cnt output when PULSE_SCHED_LATE_CNT_EN is defined.
module pulse_sched
  import pulse_sched_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int TIME_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sync_start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TIME_WIDTH-1:0]  in_time,
  input  logic [ENV_W-1:0]       in_env,
  input  logic [PHASE_W-1:0]     in_phase,
  input  logic [FREQ_W-1:0]      in_freq,
  input  logic [AMP_W-1:0]       in_amp,
  input  logic [CFG_W-1:0]       in_cfg,
  input  logic [2:0]             elem_busy,
  output logic [2:0]             out_stb,
  output logic [ENV_W-1:0]       out_env,
  output logic [PHASE_W-1:0]     out_phase,
  output logic [FREQ_W-1:0]      out_freq,
  output logic [AMP_W-1:0]       out_amp,
  output logic [1:0]             out_mode,
  output logic [TIME_WIDTH-1:0]  timer,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   late,
  output logic                   err_cfg,
  output logic                   idle
`ifdef PULSE_SCHED_LATE_CNT_EN
  ,
  output logic [15:0]            late_cnt
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic signed [TIME_WIDTH-1:0] ZERO_T = '0;

  sched_state_t          state, state_nxt;
  logic                  running;
  logic                  push, pop, due, tgt_busy, fire;
  logic [1:0]            tgt;
  logic [TIME_WIDTH-1:0] head_time;
  pulse_cmd_t            in_cmd, head_cmd;

  assign in_ready = fifo_count < CW'(DEPTH);
  assign push     = in_valid & in_ready;
  assign idle     = (fifo_count == '0) && (state == S_IDLE);
  assign in_cmd   = '{env: in_env, phase: in_phase, freq: in_freq, amp: in_amp, cfg: in_cfg};
  assign tgt      = head_cmd.cfg[1:0];
  // Signed difference keeps the compare correct across timer wrap.
  assign due      = $signed(timer - head_time) >= ZERO_T;
  assign fire     = (state == S_WAIT_ELEM) && !tgt_busy && !sync_start;

  pulse_cmd_fifo #(
    .DEPTH      (DEPTH),
    .TIME_WIDTH (TIME_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (sync_start),
    .push      (push),
    .pop       (pop),
    .push_time (in_time),
    .push_cmd  (in_cmd),
    .head_time (head_time),
    .head_cmd  (head_cmd),
    .count     (fifo_count)
  );

  always_comb begin
    tgt_busy = 1'b0;
    case (tgt)
      TGT_QDRV: tgt_busy = elem_busy[0];
      TGT_RDRV: tgt_busy = elem_busy[1];
      TGT_RDLO: tgt_busy = elem_busy[2];
      default:  tgt_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer   <= '0;
      running <= 1'b0;
    end else if (sync_start) begin
      timer   <= '0;
      running <= 1'b1;
    end else if (running) begin
      timer <= timer + TIME_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:      if (fifo_count != '0 && running) state_nxt = S_WAIT_TIME;
      S_WAIT_TIME: if (due) state_nxt = S_WAIT_ELEM;
      S_WAIT_ELEM: if (!tgt_busy) state_nxt = S_ISSUE;
      S_ISSUE: begin
        pop       = 1'b1;
        state_nxt = (fifo_count > CW'(1) || push) ? S_WAIT_TIME : S_IDLE;
      end
      default:     state_nxt = S_IDLE;
    endcase
    if (sync_start) state_nxt = S_IDLE;
  end

  // Strobe and data are captured on the edge entering ISSUE so they appear together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_stb   <= '0;
      err_cfg   <= 1'b0;
      late      <= 1'b0;
      out_env   <= '0;
      out_phase <= '0;
      out_freq  <= '0;
      out_amp   <= '0;
      out_mode  <= '0;
    end else begin
      out_stb <= '0;
      err_cfg <= 1'b0;
      late    <= 1'b0;
      if (fire) begin
        late <= (timer - TIME_WIDTH'(1)) != head_time;
        if (tgt == 2'd3) begin
          err_cfg <= 1'b1;
        end else begin
          out_stb   <= 3'(1) << tgt;
          out_env   <= head_cmd.env;
          out_phase <= head_cmd.phase;
          out_freq  <= head_cmd.freq;
          out_amp   <= head_cmd.amp;
          out_mode  <= head_cmd.cfg[3:2];
        end
      end
    end
  end

`ifdef PULSE_SCHED_LATE_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       late_cnt <= '0;
    else if (sync_start)                late_cnt <= '0;
    else if (late && late_cnt != '1)    late_cnt <= late_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pulse_sched.sv
// tb/tb_pulse_sched.sv - directed bench with a queue-based reference model of pulse_sched
module tb_pulse_sched;
  localparam int TW = 8;
  localparam int DP = 8;
  localparam int CW = $clog2(DP) + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sync_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [TW-1:0] in_time = '0;
  logic [23:0]   in_env = '0;
  logic [16:0]   in_phase = '0;
  logic [8:0]    in_freq = '0;
  logic [15:0]   in_amp = '0;
  logic [3:0]    in_cfg = '0;
  logic [2:0]    elem_busy = '0;
  logic [2:0]    out_stb;
  logic [23:0]   out_env;
  logic [16:0]   out_phase;
  logic [8:0]    out_freq;
  logic [15:0]   out_amp;
  logic [1:0]    out_mode;
  logic [TW-1:0] timer;
  logic [CW-1:0] fifo_count;
  logic          late, err_cfg, idle;
`ifdef PULSE_SCHED_LATE_CNT_EN
  logic [15:0]   late_cnt;
`endif

  pulse_sched #(.DEPTH(DP), .TIME_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .sync_start(sync_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
    .in_env(in_env), .in_phase(in_phase), .in_freq(in_freq), .in_amp(in_amp), .in_cfg(in_cfg),
    .elem_busy(elem_busy), .out_stb(out_stb), .out_env(out_env), .out_phase(out_phase),
    .out_freq(out_freq), .out_amp(out_amp), .out_mode(out_mode), .timer(timer),
    .fifo_count(fifo_count), .late(late), .err_cfg(err_cfg), .idle(idle)
`ifdef PULSE_SCHED_LATE_CNT_EN
    , .late_cnt(late_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [TW-1:0] t;
    logic [23:0]   env;
    logic [16:0]   phase;
    logic [8:0]    freq;
    logic [15:0]   amp;
    logic [3:0]    cfg;
  } cmd_t;

  // Model: queue of commands plus cycle stamps for when the head becomes due and issues.
  cmd_t          mq[$];
  cmd_t          m_iss;
  logic [TW-1:0] m_tmr;
  bit            m_run;
  int            cyc = 0;
  int            m_eval_at, m_due_at, m_issue_at;
  logic [23:0]   e_env;
  logic [16:0]   e_phase;
  logic [8:0]    e_freq;
  logic [15:0]   e_amp;
  logic [1:0]    e_mode;
`ifdef PULSE_SCHED_LATE_CNT_EN
  logic [15:0]   m_lcnt;
`endif

  always @(negedge clk) begin
    logic          fire, e_err, e_late, push, busy;
    logic [2:0]    e_stb;
    logic [TW-1:0] lag;
    cmd_t          nc;
    cyc++;
    if (!reset_n) begin
      mq.delete();
      m_tmr = '0; m_run = 0;
      m_eval_at = -1; m_due_at = -1; m_issue_at = -1;
      e_env = '0; e_phase = '0; e_freq = '0; e_amp = '0; e_mode = '0;
`ifdef PULSE_SCHED_LATE_CNT_EN
      m_lcnt = '0;
`endif
    end
    fire = reset_n && (m_issue_at == cyc);
    e_stb = '0; e_err = 1'b0; e_late = 1'b0;
    if (fire) begin
      e_late = (m_tmr - TW'(2)) != m_iss.t;
      if (m_iss.cfg[1:0] == 2'd3) e_err = 1'b1;
      else begin
        e_stb = 3'b001 << m_iss.cfg[1:0];
        e_env = m_iss.env; e_phase = m_iss.phase; e_freq = m_iss.freq;
        e_amp = m_iss.amp; e_mode = m_iss.cfg[3:2];
      end
    end
    chk("timer", timer, m_tmr);
    chk("fifo_count", fifo_count, mq.size());
    chk("in_ready", in_ready, mq.size() < DP);
    chk("idle", idle, mq.size() == 0);
    chk("out_stb", out_stb, e_stb);
    chk("err_cfg", err_cfg, e_err);
    chk("late", late, e_late);
    chk("out_env", out_env, e_env);
    chk("out_phase", out_phase, e_phase);
    chk("out_freq", out_freq, e_freq);
    chk("out_amp", out_amp, e_amp);
    chk("out_mode", out_mode, e_mode);
`ifdef PULSE_SCHED_LATE_CNT_EN
    chk("late_cnt", late_cnt, m_lcnt);
    if (reset_n) begin
      if (sync_start) m_lcnt = '0;
      else if (e_late && m_lcnt != 16'hFFFF) m_lcnt = m_lcnt + 16'd1;
    end
`endif
    if (reset_n) begin
      push = in_valid && (mq.size() < DP);
      nc.t = in_time; nc.env = in_env; nc.phase = in_phase;
      nc.freq = in_freq; nc.amp = in_amp; nc.cfg = in_cfg;
      if (sync_start) begin
        mq.delete();
        if (push) mq.push_back(nc);
        m_tmr = '0; m_run = 1;
        m_eval_at = -1; m_due_at = -1; m_issue_at = -1;
      end else begin
        if (fire) begin
          void'(mq.pop_front());
          m_issue_at = -1; m_due_at = -1;
          m_eval_at = (mq.size() > 0 || push) ? cyc + 1 : -1;
        end else if (m_eval_at < 0) begin
          if (mq.size() > 0 && m_run) m_eval_at = cyc + 1;
        end else if (m_due_at < 0) begin
          if (cyc >= m_eval_at) begin
            lag = m_tmr - mq[0].t;
            if (!lag[TW-1]) m_due_at = cyc;
          end
        end else if (m_issue_at < 0 && cyc > m_due_at) begin
          busy = (mq[0].cfg[1:0] == 2'd3) ? 1'b0 : elem_busy[mq[0].cfg[1:0]];
          if (!busy) begin
            m_issue_at = cyc + 1;
            m_iss = mq[0];
          end
        end
        if (push) mq.push_back(nc);
        if (m_run) m_tmr = m_tmr + TW'(1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_pulse();
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0;
  endtask

  task automatic push_cmd(input logic [TW-1:0] t, input logic [3:0] cfg, input logic [15:0] amp);
    in_valid = 1'b1; in_time = t; in_cfg = cfg; in_amp = amp;
    in_env = {amp, 8'h3C}; in_phase = {amp[0], amp}; in_freq = amp[8:0] ^ 9'h1A5;
    step(1);
    in_valid = 1'b0;
  endtask

  task automatic wait_stb(input int bound, input string nm);
    int  k = 0;
    bit  got = 0;
    while (k < bound && !got) begin
      @(negedge clk);
      if (out_stb != 3'b000 || err_cfg) got = 1;
      k++;
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL %s: no strobe within %0d cycles", nm, bound);
    end
  endtask

  initial begin
    step(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_timer", timer, 0);
    chk("rst_stb", out_stb, 0);
    reset_n = 1'b1;
    step(2);
    chk("stopped_timer", timer, 0);

    // Fill past depth while the timer is stopped
    in_valid = 1'b1; in_time = 8'd100; in_cfg = 4'h0; in_amp = 16'h0001;
    step(8);
    chk("full_ready", in_ready, 0);
    chk("full_count", fifo_count, 8);
    step(1);
    in_valid = 1'b0;
    chk("full_count_stall", fifo_count, 8);

    // Flush, queue three far-future commands, restart at timer=50
    sync_pulse();
    chk("flush_count", fifo_count, 0);
    push_cmd(8'd120, 4'h0, 16'h1111);
    push_cmd(8'd120, 4'h1, 16'h2222);
    push_cmd(8'd120, 4'h2, 16'h3333);
    step(47);
    chk("pre_sync_timer", timer, 50);
    chk("pre_sync_count", fifo_count, 3);
    sync_pulse();
    chk("restart_timer", timer, 0);
    chk("restart_count", fifo_count, 0);

    // Basic issue: time=10 -> strobe at 12
    push_cmd(8'd10, 4'h0, 16'h1234);
    wait_stb(30, "basic");
    chk("basic_stb", out_stb, 3'b001);
    chk("basic_timer", timer, 12);
    chk("basic_amp", out_amp, 16'h1234);
    chk("basic_late", late, 0);

    // Busy target holds the issue until it frees
    sync_pulse();
    elem_busy = 3'b010;
    push_cmd(8'd5, 4'h1, 16'h5555);
    step(20);
    elem_busy = 3'b000;
    wait_stb(10, "busy");
    chk("busy_stb", out_stb, 3'b010);
    chk("busy_timer", timer, 22);
    chk("busy_late", late, 1);

    // Invalid target: popped with err_cfg, no strobe
    sync_pulse();
    push_cmd(8'd3, 4'h3, 16'h0BAD);
    wait_stb(15, "cfg3");
    chk("cfg3_err", err_cfg, 1);
    chk("cfg3_timer", timer, 5);
    chk("cfg3_stb", out_stb, 0);
    step(1);
    chk("cfg3_count", fifo_count, 0);

    // Wrap: pushed at 250 for time 4 issues at 6
    sync_pulse();
    step(250);
    push_cmd(8'd4, 4'b1110, 16'h7777);
    wait_stb(30, "wrap");
    chk("wrap_stb", out_stb, 3'b100);
    chk("wrap_timer", timer, 6);
    chk("wrap_mode", out_mode, 2'd3);
    chk("wrap_late", late, 0);

    // Equal times issue in order; push during a pop keeps the count
    sync_pulse();
    push_cmd(8'd20, 4'h0, 16'hA1A1);
    push_cmd(8'd20, 4'h1, 16'hB2B2);
    push_cmd(8'd20, 4'h2, 16'hC3C3);
    step(19);
    chk("order_first_stb", out_stb, 3'b001);
    chk("order_first_timer", timer, 22);
    chk("order_first_count", fifo_count, 3);
    push_cmd(8'd20, 4'h0, 16'hD4D4);
    chk("pushpop_count", fifo_count, 3);
    step(2);
    chk("order_second_stb", out_stb, 3'b010);
    chk("order_second_amp", out_amp, 16'hB2B2);
    step(12);

    // Arrival after its time is flagged late
    sync_pulse();
    step(10);
    push_cmd(8'd1, 4'h2, 16'h4242);
    wait_stb(10, "late_arrival");
    chk("late_arr_timer", timer, 14);
    chk("late_arr_flag", late, 1);

    // Push coinciding with sync_start survives the flush
    push_cmd(8'd200, 4'h0, 16'h0101);
    in_valid = 1'b1; in_time = 8'd90; in_cfg = 4'h1; in_amp = 16'h9090;
    sync_start = 1'b1;
    step(1);
    sync_start = 1'b0; in_valid = 1'b0;
    chk("sync_push_count", fifo_count, 1);
    step(3);

    // Reset during ISSUE drops the strobe at once
    sync_pulse();
    push_cmd(8'd3, 4'h0, 16'h0BEE);
    wait_stb(10, "mid_issue");
    chk("mid_issue_stb", out_stb, 3'b001);
    #1 reset_n = 1'b0;
    #1;
    chk("trunc_stb", out_stb, 0);
    chk("trunc_timer", timer, 0);
    chk("trunc_idle", idle, 1);
    step(2);
    reset_n = 1'b1;
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
